// File: rtl/axi_dmi_pkg.sv
// Shared constants for the AXI-Lite to DMI responder: FSM encodings,
// AXI response codes, DMI-to-AXI response mapping and timeout limits.
package axi_dmi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_BRESP = 3'd3;
    localparam logic [2:0] ST_RRESP = 3'd4;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    localparam logic [15:0] TIMEOUT_MAX   = 16'hFFFF;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // DMI resp 0 is success; failed, busy and the reserved code all error out.
    function automatic logic [1:0] dmi2axi_resp(input logic [1:0] resp);
        return (resp == 2'd0) ? AXI_OKAY : AXI_SLVERR;
    endfunction

endpackage

// File: rtl/dm.sv
// Minimal stand-in for the debug module's dm package: DMI request/response
// types and DTM op codes as seen on the DMI port.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/axi_dmi_if.sv
// AXI-Lite bus (32-bit data, 4-bit strobe) with master/slave views.
interface axi_dmi_if;

    logic [31:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready,
               r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready,
               r_data, r_resp, r_valid
    );

endinterface

// File: rtl/axi_dmi_wcapture.sv
// Independent AW and W holding registers; each channel is accepted on its own
// while the bridge is idle, and both are released once the B beat is taken.
module axi_dmi_wcapture #(
    parameter int unsigned DmiAddrWidth = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept_en,
    input  logic                    clear,
    input  logic [DmiAddrWidth-1:0] aw_addr,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [31:0]             w_data,
    input  logic [3:0]              w_strb,
    input  logic                    w_valid,
    output logic                    w_ready,
    output logic                    aw_held,
    output logic                    w_held,
    output logic [DmiAddrWidth-1:0] addr_q,
    output logic [31:0]             data_q,
    output logic [3:0]              strb_q
);

    assign aw_ready = accept_en & ~aw_held;
    assign w_ready  = accept_en & ~w_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (clear) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_ready && aw_valid) begin
                aw_held <= 1'b1;
                addr_q  <= aw_addr;
            end
            if (w_ready && w_valid) begin
                w_held <= 1'b1;
                data_q <= w_data;
                strb_q <= w_strb;
            end
        end
    end

endmodule

// File: rtl/axi_dmi.sv
// AXI-Lite responder issuing one DMI request per access, one at a time.
// Define AXI_DMI_TIMEOUT_EN to abort stalled DMI accesses with SLVERR.
module axi_dmi
    import axi_dmi_pkg::*;
#(
    parameter int unsigned AddrLsb      = 2,
    parameter int unsigned DmiAddrWidth = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_dmi_if.slave      axilite,
    output dm::dmi_req_t  dmi_req_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    input  dm::dmi_resp_t dmi_resp_i,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o
);

    logic [2:0]              state_q;
    logic                    live_q, rr_q, is_rd_q;
    logic                    aw_held, w_held;
    logic [DmiAddrWidth-1:0] waddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic                    idle, wr_pending, rd_go, wr_go, contested, b_done;
    dm::dmi_req_t            req_q;
    logic                    req_valid_q, b_valid_q, r_valid_q;
    logic [1:0]              b_resp_q, r_resp_q;
    logic [31:0]             r_data_q;
    logic                    tmo_hit, fin;
    logic [1:0]              fin_resp;
    logic [31:0]             fin_data;
    logic                    unused_addr_bits;

    // live_q keeps every ready low while reset is held and for the first edge after.
    assign idle       = live_q && (state_q == ST_IDLE);
    assign wr_pending = aw_held & w_held;
    assign axilite.ar_ready = idle & ~(aw_held ^ w_held) & (~wr_pending | rr_q);
    assign rd_go      = axilite.ar_ready & axilite.ar_valid;
    assign wr_go      = idle & wr_pending & ~rd_go;
    // Round-robin only advances when a full write and a read actually compete.
    assign contested  = idle & wr_pending & axilite.ar_valid;
    assign b_done     = (state_q == ST_BRESP) & axilite.b_ready;

    assign unused_addr_bits = ^{axilite.aw_addr, axilite.ar_addr};

    axi_dmi_wcapture #(.DmiAddrWidth(DmiAddrWidth)) u_wcapture (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_en(idle),
        .clear    (b_done),
        .aw_addr  (axilite.aw_addr[AddrLsb +: DmiAddrWidth]),
        .aw_valid (axilite.aw_valid),
        .aw_ready (axilite.aw_ready),
        .w_data   (axilite.w_data),
        .w_strb   (axilite.w_strb),
        .w_valid  (axilite.w_valid),
        .w_ready  (axilite.w_ready),
        .aw_held  (aw_held),
        .w_held   (w_held),
        .addr_q   (waddr_q),
        .data_q   (wdata_q),
        .strb_q   (wstrb_q)
    );

`ifdef AXI_DMI_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        drain_q;

    assign tmo_hit = (tmo_q == TIMEOUT_MAX);
    // One idle cycle of resp_ready swallows a response that shows up after abort.
    assign dmi_resp_ready_o = (state_q == ST_RESP) | (idle & drain_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == ST_REQ || state_q == ST_RESP) ? tmo_q + 16'd1 : '0;
            if (tmo_hit && (state_q == ST_REQ || state_q == ST_RESP))
                drain_q <= 1'b1;
            else if (state_q == ST_IDLE)
                drain_q <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign dmi_resp_ready_o = (state_q == ST_RESP);
`endif

    always_comb begin
        fin      = 1'b0;
        fin_resp = AXI_SLVERR;
        fin_data = TIMEOUT_RDATA;
        if (state_q == ST_RESP && dmi_resp_valid_i) begin
            fin      = 1'b1;
            fin_resp = dmi2axi_resp(dmi_resp_i.resp);
            fin_data = dmi_resp_i.data;
        end else if (tmo_hit && ((state_q == ST_REQ && !dmi_req_ready_i) ||
                                 state_q == ST_RESP)) begin
            fin = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            live_q      <= 1'b0;
            rr_q        <= 1'b0;
            is_rd_q     <= 1'b0;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= AXI_OKAY;
            r_valid_q   <= 1'b0;
            r_resp_q    <= AXI_OKAY;
            r_data_q    <= '0;
        end else begin
            live_q <= 1'b1;
            if (contested) rr_q <= ~rr_q;
            case (state_q)
                ST_IDLE: begin
                    if (rd_go) begin
                        req_q       <= '{addr: axilite.ar_addr[AddrLsb +: DmiAddrWidth],
                                         op: dm::DTM_READ, data: '0};
                        req_valid_q <= 1'b1;
                        is_rd_q     <= 1'b1;
                        state_q     <= ST_REQ;
                    end else if (wr_go) begin
                        is_rd_q <= 1'b0;
                        if (wstrb_q != 4'hF) begin
                            b_resp_q  <= AXI_SLVERR;
                            b_valid_q <= 1'b1;
                            state_q   <= ST_BRESP;
                        end else begin
                            req_q       <= '{addr: waddr_q, op: dm::DTM_WRITE, data: wdata_q};
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmi_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: ;
                ST_BRESP: begin
                    if (axilite.b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (axilite.r_ready) begin
                        r_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (fin) begin
                req_valid_q <= 1'b0;
                if (is_rd_q) begin
                    r_data_q  <= fin_data;
                    r_resp_q  <= fin_resp;
                    r_valid_q <= 1'b1;
                    state_q   <= ST_RRESP;
                end else begin
                    b_resp_q  <= fin_resp;
                    b_valid_q <= 1'b1;
                    state_q   <= ST_BRESP;
                end
            end
        end
    end

    assign dmi_req_o       = req_q;
    assign dmi_req_valid_o = req_valid_q;
    assign axilite.b_valid = b_valid_q;
    assign axilite.b_resp  = b_resp_q;
    assign axilite.r_valid = r_valid_q;
    assign axilite.r_resp  = r_resp_q;
    assign axilite.r_data  = r_data_q;

endmodule
